// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and forwarding controller for a 5-stage MIPS pipeline. A shadow copy
// of the destination information of the instructions in EX and MEM is kept
// alongside the datapath. From it the block derives load-use stalls, branch
// squashes and registered EX-stage operand forwarding selects.
// The WB stage is not shadowed. The register file is write-through, so a
// producer in WB never needs a forward and nothing would ever read that entry.

module pipe_hazard_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] id_ir,
   input  logic        ex_branch_taken,
   input  logic        ex_movz_cond,
   output logic        pc_wen,
   output logic        if_id_wen,
   output logic        if_id_flush,
   output logic        id_ex_bubble,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   localparam logic [5:0]  OP_RTYPE   = 6'b000000;
   localparam logic [5:0]  OP_J       = 6'b000010;
   localparam logic [5:0]  OP_BEQ     = 6'b000100;
   localparam logic [5:0]  OP_LW      = 6'b100011;
   localparam logic [5:0]  OP_SW      = 6'b101011;
   localparam logic [10:0] MOVZ_TAIL  = 11'b00000_001010;

   localparam logic [1:0]  FWD_REGFILE = 2'b00;
   localparam logic [1:0]  FWD_EXMEM   = 2'b10;
   localparam logic [1:0]  FWD_MEMWB   = 2'b01;

   // Decoded fields of the instruction sitting in ID
   logic [4:0]  w_srcA;
   logic [4:0]  w_srcB;
   logic [4:0]  w_dst;
   logic        w_dstWen;
   logic        w_dstLoad;
   logic        w_dstMovz;

   // Shadow EX entry
   logic [4:0]  r_exDst;
   logic        r_exWen;
   logic        r_exIsLoad;
   logic        r_exIsMovz;

   // Shadow MEM entry; only dst and the resolved wen matter past EX
   logic [4:0]  r_memDst;
   logic        r_memWen;

   logic        w_exEffWen;
   logic        w_exHitA;
   logic        w_exHitB;
   logic        w_loadUse;
   logic        w_branch;
   logic [1:0]  w_fwdA;
   logic [1:0]  w_fwdB;

   logic [1:0]  r_fwdA;
   logic [1:0]  r_fwdB;
   logic [15:0] r_stallCnt;
   logic [15:0] r_flushCnt;

   // Register r0 is used as "no operand", so absent sources/destinations
   // decode to 0 and can never match a producer.
   always_comb begin
      w_srcA    = 5'd0;
      w_srcB    = 5'd0;
      w_dst     = 5'd0;
      w_dstWen  = 1'b0;
      w_dstLoad = 1'b0;
      w_dstMovz = 1'b0;
      case (id_ir[31:26])
         OP_LW: begin
            w_srcA    = id_ir[25:21];
            w_dst     = id_ir[20:16];
            w_dstWen  = 1'b1;
            w_dstLoad = 1'b1;
         end
         OP_SW, OP_BEQ: begin
            w_srcA = id_ir[25:21];
            w_srcB = id_ir[20:16];
         end
         OP_RTYPE: begin
            w_srcA    = id_ir[25:21];
            w_srcB    = id_ir[20:16];
            w_dst     = id_ir[15:11];
            w_dstWen  = 1'b1;
            w_dstMovz = (id_ir[10:0] == MOVZ_TAIL);
         end
         OP_J: begin
            w_srcA = 5'd0;
         end
         default: begin
            w_srcA = 5'd0;
         end
      endcase
   end

   // Producer matching against the EX entry and forward select generation.
   // A MOVZ in EX only counts as a writer when its condition holds this cycle.
   always_comb begin
      w_exEffWen = r_exIsMovz ? ex_movz_cond : r_exWen;
      w_exHitA   = (w_srcA != 5'd0) && (w_srcA == r_exDst);
      w_exHitB   = (w_srcB != 5'd0) && (w_srcB == r_exDst);
      w_loadUse  = r_exIsLoad && r_exWen && (w_exHitA || w_exHitB);

      w_fwdA = FWD_REGFILE;
      if (w_exHitA && w_exEffWen && !r_exIsLoad) begin
         w_fwdA = FWD_EXMEM;
      end else if ((w_srcA != 5'd0) && (w_srcA == r_memDst) && r_memWen) begin
         w_fwdA = FWD_MEMWB;
      end

      w_fwdB = FWD_REGFILE;
      if (w_exHitB && w_exEffWen && !r_exIsLoad) begin
         w_fwdB = FWD_EXMEM;
      end else if ((w_srcB != 5'd0) && (w_srcB == r_memDst) && r_memWen) begin
         w_fwdB = FWD_MEMWB;
      end
   end

   // Pipeline control; a taken branch squashes the stalled consumer anyway,
   // so it overrides a load-use stall. Held quiet while in reset.
   always_comb begin
      w_branch     = ex_branch_taken && resetn;
      pc_wen       = 1'b1;
      if_id_wen    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      if (w_branch) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (w_loadUse) begin
         pc_wen       = 1'b0;
         if_id_wen    = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   // Shadow pipeline shift; the MOVZ condition is resolved as it leaves EX
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_exDst    <= 5'd0;
         r_exWen    <= 1'b0;
         r_exIsLoad <= 1'b0;
         r_exIsMovz <= 1'b0;
         r_memDst   <= 5'd0;
         r_memWen   <= 1'b0;
      end else begin
         if (id_ex_bubble) begin
            r_exDst    <= 5'd0;
            r_exWen    <= 1'b0;
            r_exIsLoad <= 1'b0;
            r_exIsMovz <= 1'b0;
         end else begin
            r_exDst    <= w_dst;
            r_exWen    <= w_dstWen;
            r_exIsLoad <= w_dstLoad;
            r_exIsMovz <= w_dstMovz;
         end
         r_memDst <= r_exDst;
         r_memWen <= w_exEffWen;
      end
   end

   // Forward selects travel with the instruction into EX; a bubble carries none
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_fwdA <= FWD_REGFILE;
         r_fwdB <= FWD_REGFILE;
      end else if (id_ex_bubble) begin
         r_fwdA <= FWD_REGFILE;
         r_fwdB <= FWD_REGFILE;
      end else begin
         r_fwdA <= w_fwdA;
         r_fwdB <= w_fwdB;
      end
   end

   // Saturating event counters; a stall squashed by a branch is not counted
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_stallCnt <= 16'd0;
         r_flushCnt <= 16'd0;
      end else begin
         if (w_loadUse && !w_branch && (r_stallCnt != 16'hFFFF)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
         end
         if (w_branch && (r_flushCnt != 16'hFFFF)) begin
            r_flushCnt <= r_flushCnt + 16'd1;
         end
      end
   end

   assign fwd_a     = r_fwdA;
   assign fwd_b     = r_fwdB;
   assign stall_cnt = r_stallCnt;
   assign flush_cnt = r_flushCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. The bench plays the role of the
// fetch/decode datapath by presenting one instruction in ID per cycle.

module tb_pipe_hazard_ctrl;

   logic        clk;
   logic        resetn;
   logic [31:0] id_ir;
   logic        ex_branch_taken;
   logic        ex_movz_cond;
   logic        pc_wen;
   logic        if_id_wen;
   logic        if_id_flush;
   logic        id_ex_bubble;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   int checkCount = 0;
   int errorCount = 0;

   // {pc_wen, if_id_wen, if_id_flush, id_ex_bubble}
   localparam logic [3:0] CTL_NORMAL = 4'b1100;
   localparam logic [3:0] CTL_STALL  = 4'b0001;
   localparam logic [3:0] CTL_BRANCH = 4'b1111;

   pipe_hazard_ctrl dut (
      .clk             (clk),
      .resetn          (resetn),
      .id_ir           (id_ir),
      .ex_branch_taken (ex_branch_taken),
      .ex_movz_cond    (ex_movz_cond),
      .pc_wen          (pc_wen),
      .if_id_wen       (if_id_wen),
      .if_id_flush     (if_id_flush),
      .id_ex_bubble    (id_ex_bubble),
      .fwd_a           (fwd_a),
      .fwd_b           (fwd_b),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
      return {6'b000000, rs, rt, rd, 5'b00000, funct};
   endfunction

   function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] ir, input logic br, input logic mc);
      @(negedge clk);
      id_ir           = ir;
      ex_branch_taken = br;
      ex_movz_cond    = mc;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkCtl(input string tag, input logic [3:0] expected);
      checkOutput(tag, {28'd0, pc_wen, if_id_wen, if_id_flush, id_ex_bubble}, {28'd0, expected});
   endtask

   task automatic checkFwd(input string tag, input logic [3:0] expected);
      checkOutput(tag, {28'd0, fwd_a, fwd_b}, {28'd0, expected});
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(32'd0, 1'b0, 1'b0);
         tick();
      end
   endtask

   logic [31:0] add3_1_2, sub4_3_1, lw5_0_1, add6_5_5, sw3_4_2;
   logic [31:0] movz7_1_2, add8_7_0, add9_7_0, add1_2_3;
   logic [15:0] satExpect [3];

   initial begin
      add3_1_2  = rType(5'd1, 5'd2, 5'd3, 6'h20);
      sub4_3_1  = rType(5'd3, 5'd1, 5'd4, 6'h22);
      add6_5_5  = rType(5'd5, 5'd5, 5'd6, 6'h20);
      movz7_1_2 = rType(5'd1, 5'd2, 5'd7, 6'h0A);
      add8_7_0  = rType(5'd7, 5'd0, 5'd8, 6'h20);
      add9_7_0  = rType(5'd7, 5'd0, 5'd9, 6'h20);
      add1_2_3  = rType(5'd2, 5'd3, 5'd1, 6'h20);
      lw5_0_1   = iType(6'b100011, 5'd1, 5'd5, 16'd0);
      sw3_4_2   = iType(6'b101011, 5'd2, 5'd3, 16'd4);
      satExpect[0] = 16'hFFFE;
      satExpect[1] = 16'hFFFF;
      satExpect[2] = 16'hFFFF;

      resetn          = 1'b0;
      id_ir           = 32'd0;
      ex_branch_taken = 1'b0;
      ex_movz_cond    = 1'b0;
      #2;
      checkCtl("reset_ctl", CTL_NORMAL);
      checkFwd("reset_fwd", 4'b0000);
      checkOutput("reset_stall", {16'd0, stall_cnt}, 32'd0);
      checkOutput("reset_flush", {16'd0, flush_cnt}, 32'd0);
      #10;
      resetn = 1'b1;

      // Back-to-back dependent R-types forward from EX/MEM
      applyStimulus(add3_1_2, 1'b0, 1'b0);
      checkCtl("add_ctl", CTL_NORMAL);
      tick();
      checkFwd("add_fwd", 4'b0000);
      applyStimulus(sub4_3_1, 1'b0, 1'b0);
      checkCtl("sub_ctl", CTL_NORMAL);
      tick();
      checkFwd("sub_fwd", 4'b1000);
      nops(3);

      // Load-use: one stall, then forward from MEM/WB
      applyStimulus(lw5_0_1, 1'b0, 1'b0);
      checkCtl("lw_ctl", CTL_NORMAL);
      tick();
      applyStimulus(add6_5_5, 1'b0, 1'b0);
      checkCtl("lu_stall_ctl", CTL_STALL);
      tick();
      checkFwd("lu_bubble_fwd", 4'b0000);
      checkOutput("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
      applyStimulus(add6_5_5, 1'b0, 1'b0);
      checkCtl("lu_resume_ctl", CTL_NORMAL);
      tick();
      checkFwd("lu_fwd", 4'b0101);
      checkOutput("lu_stall_cnt2", {16'd0, stall_cnt}, 32'd1);
      nops(3);

      // Producer two ahead forwards from MEM/WB into SW's rt
      applyStimulus(add3_1_2, 1'b0, 1'b0);
      tick();
      applyStimulus(32'd0, 1'b0, 1'b0);
      tick();
      applyStimulus(sw3_4_2, 1'b0, 1'b0);
      checkCtl("sw_ctl", CTL_NORMAL);
      tick();
      checkFwd("sw_fwd", 4'b0001);
      nops(3);

      // MOVZ with false condition: no forward from EX nor MEM
      applyStimulus(movz7_1_2, 1'b0, 1'b0);
      tick();
      applyStimulus(add8_7_0, 1'b0, 1'b0);
      tick();
      checkFwd("movz0_ex_fwd", 4'b0000);
      applyStimulus(add9_7_0, 1'b0, 1'b0);
      tick();
      checkFwd("movz0_mem_fwd", 4'b0000);
      nops(3);

      // MOVZ with true condition forwards like a normal producer
      applyStimulus(movz7_1_2, 1'b0, 1'b0);
      tick();
      applyStimulus(add8_7_0, 1'b0, 1'b1);
      tick();
      checkFwd("movz1_ex_fwd", 4'b1000);
      applyStimulus(add9_7_0, 1'b0, 1'b0);
      tick();
      checkFwd("movz1_mem_fwd", 4'b0100);
      nops(3);

      // Branch beats a pending load-use stall
      applyStimulus(lw5_0_1, 1'b0, 1'b0);
      tick();
      applyStimulus(add6_5_5, 1'b1, 1'b0);
      checkCtl("br_ctl", CTL_BRANCH);
      tick();
      checkOutput("br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
      checkOutput("br_stall_cnt", {16'd0, stall_cnt}, 32'd1);
      checkFwd("br_fwd", 4'b0000);
      nops(3);

      // Saturation of stall_cnt from a preloaded value near the top
      @(negedge clk);
      #1;
      force dut.r_stallCnt = 16'hFFFD;
      #1;
      release dut.r_stallCnt;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(lw5_0_1, 1'b0, 1'b0);
         tick();
         applyStimulus(add6_5_5, 1'b0, 1'b0);
         checkCtl($sformatf("sat_ctl%0d", i), CTL_STALL);
         tick();
         checkOutput($sformatf("sat_cnt%0d", i), {16'd0, stall_cnt}, {16'd0, satExpect[i]});
      end
      nops(2);

      // Asynchronous reset in the middle of a stall
      applyStimulus(add1_2_3, 1'b0, 1'b0);
      tick();
      applyStimulus(lw5_0_1, 1'b0, 1'b0);
      tick();
      checkFwd("pre_rst_fwd", 4'b1000);
      applyStimulus(add6_5_5, 1'b0, 1'b0);
      checkCtl("pre_rst_ctl", CTL_STALL);
      #1;
      resetn = 1'b0;
      #1;
      checkCtl("mid_rst_ctl", CTL_NORMAL);
      checkFwd("mid_rst_fwd", 4'b0000);
      checkOutput("mid_rst_stall", {16'd0, stall_cnt}, 32'd0);
      checkOutput("mid_rst_flush", {16'd0, flush_cnt}, 32'd0);
      #1;
      resetn = 1'b1;
      #0.5;
      checkCtl("post_rst_ctl", CTL_NORMAL);
      tick();
      checkOutput("post_rst_stall", {16'd0, stall_cnt}, 32'd0);
      checkFwd("post_rst_fwd", 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
